// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller with tear-free frame updates
// Optional leading-zero blanking: define SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int DIV_MAX = 49999,
    parameter int GUARD   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    output logic        ack,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int CW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV_MAX);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [15:0]   disp_q;
    logic [3:0]    dp_q;
    logic [15:0]   pend_q;
    logic [3:0]    pend_dp_q;
    logic          pend_valid_q;
    logic          ack_q;
    logic [7:0]    seg_q;
    logic [3:0]    an_q;

    logic          tick;
    logic          frame;
    logic          in_guard;
    logic [3:0]    nib;
    logic [6:0]    seg_bits;
    logic [7:0]    seg_d;
    logic [3:0]    an_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // Slot timing and the segment/anode pattern for the current slot position.
    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        frame    = tick && (idx_q == 2'd3);
        in_guard = (cnt_q < GUARD_C);
        nib      = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_SCAN_LZB_EN
        // A digit above digit0 is blank when it and every digit above it is zero.
        case (idx_q)
            2'd3:    seg_bits = (disp_q[15:12] == 4'h0)  ? 7'b0 : seg_decode(nib);
            2'd2:    seg_bits = (disp_q[15:8]  == 8'h0)  ? 7'b0 : seg_decode(nib);
            2'd1:    seg_bits = (disp_q[15:4]  == 12'h0) ? 7'b0 : seg_decode(nib);
            default: seg_bits = seg_decode(nib);
        endcase
`else
        seg_bits = seg_decode(nib);
`endif
        an_d  = in_guard ? 4'hF : ~(4'b0001 << idx_q);
        seg_d = in_guard ? 8'h00 : {seg_bits, dp_q[idx_q]};
    end

    // Prescaler, digit index, pending/display registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0;
            dp_q         <= 4'h0;
            pend_q       <= 16'h0;
            pend_dp_q    <= 4'h0;
            pend_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            seg_q        <= 8'h00;
            an_q         <= 4'hF;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                idx_q <= idx_q + 2'd1;
            end
            // Display only moves at a frame boundary so a frame never mixes two values.
            if (frame && pend_valid_q) begin
                disp_q <= pend_q;
                dp_q   <= pend_dp_q;
            end
            ack_q <= frame && pend_valid_q;
            // A new load always lands in pending, even on the boundary that drains it.
            if (load) begin
                pend_q       <= data_in;
                pend_dp_q    <= dp_in;
                pend_valid_q <= 1'b1;
            end else if (frame) begin
                pend_valid_q <= 1'b0;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign ack = ack_q;
    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV_MAX, default 49999: prescaler terminal count; one digit slot lasts DIV_MAX+1 clk cycles.
REQ-002 Parameter GUARD, default 4: number of cycles at the start of each slot with all digits off (anti-ghosting); range 0..DIV_MAX.
REQ-003 clk  input  1: single system clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 load  input  1: one-cycle request to display new value.
REQ-006 data_in  input  16: four BCD nibbles; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
REQ-007 dp_in  input  4: decimal-point enables, bit i = digit i, captured with data_in.
REQ-008 ack  output  1: one-cycle pulse when a requested value becomes visible.
REQ-009 seg  output  8: segment pattern, bit7=a .. bit1=g, bit0=dp, active-high.
REQ-010 an  output  4: digit enables, active-low, bit i = digit i.

Function
REQ-011 Prescaler counts 0..DIV_MAX, wraps to 0; tick asserted in the cycle where count==DIV_MAX.
REQ-012 Digit index idx (2 bits) advances on tick, wrapping 3->0; tick with idx==3 is the frame boundary.
REQ-013 load captures data_in/dp_in into pending register and sets pend_valid; load while pend_valid already set overwrites pending contents (last write wins).
REQ-014 At frame boundary with pend_valid=1: display register takes pending contents, pend_valid clears, ack=1 in following cycle only.
REQ-015 load coincident with a frame boundary: the older pending value (if any) is transferred, the new value is captured as pending, pend_valid stays 1; if no older value, nothing transfers and new value waits for next boundary.
REQ-016 Display register changes only at frame boundaries; no partial-frame updates (no tearing).
REQ-017 seg and an are registered: reflect idx and prescaler count with exactly one cycle latency.
REQ-018 an = all ones while prescaler count < GUARD; otherwise an[idx]=0, other bits 1.
REQ-019 seg[7:1] decode of display nibble idx: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; nibbles 10..15 give 0000000.
REQ-020 seg[0] = display dp bit idx, independent of nibble value.
REQ-021 seg = 0 whenever an is all ones.
REQ-022 Full refresh period = 4*(DIV_MAX+1) cycles; no stall or back-pressure on load.

Reset
REQ-023 While rst=1: prescaler=0, idx=0, display=0, dp=0, pending=0, pend_valid=0, ack=0, an=1111, seg=00000000.
REQ-024 rst asserted mid-frame discards any pending load without ack; scanning restarts at digit0, count 0, on first clk after release.

Configuration
REQ-025 Macro SEG_SCAN_LZB_EN defined: digits 3..1 whose nibble is 0 and all higher digits are 0 drive seg[7:1]=0 (dp still shown); digit0 never blanked.
REQ-026 Macro SEG_SCAN_LZB_EN undefined: zero nibbles always decode to 1111110; no blanking logic present.

Verification (DIV_MAX=3, GUARD=1)
REQ-027 Reset release, no load -> an cycles 1111,1110,1110,1110,1111,1101,... ; seg=11111100 whenever an!=1111; ack never asserted.
REQ-028 load data_in=16'h1234, dp_in=4'b0010 mid-frame -> no change until frame boundary; ack one cycle later; digit0 seg=01100110, digit1 seg=11110011, digit3 seg=01100000.
REQ-029 Two loads (16'h1111 then 16'h9999) in one frame -> single ack; display 9999 (digit seg=11110110).
REQ-030 load coincident with boundary while 16'h0005 pending -> 0005 shown this frame with ack; new value shown and acked one frame later.
REQ-031 data_in=16'h00A7 -> digit1 seg=00000000, digit0 seg=11100000; with SEG_SCAN_LZB_EN, data 16'h0050 -> digits3,2 blank, digit1 seg=10110110, digit0 seg=11111100.
REQ-032 rst pulsed with value pending mid-frame -> all outputs to reset values immediately, no ack, pending value never displayed.
